coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Snooping bus controller for the two-core MSI system; sits between both L1 dcaches and the shared RAM port.
- Arbitrates cache bus requests (BUSRD, BUSRDX, INVALIDATE, WB) round-robin.
- Broadcasts each granted transaction as a snoop to the other cache and sequences the memory read, writeback or cache-to-cache flush.
- Returns read data and a one-cycle done pulse to the requester.

Parameters:
ADDR_W, 32, address width (word address as in cpu_types_pkg word_t)
DATA_W, 32, data width per transfer

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
cache_req  in  2  bit i = cache i requests the bus
cache_cmd  in  2x3  bus_command per cache; IDLE encoding = no request
cache_addr  in  2xADDR_W  transaction address per cache
cache_wdata  in  2xDATA_W  WB data per cache
cache_done  out  2  one-cycle completion pulse to the requester
cache_rdata  out  DATA_W  fill data, valid with cache_done
snoop_valid  out  2  bit i = cache i must snoop
snoop_cmd  out  3  bus_command being snooped
snoop_addr  out  ADDR_W  snooped address
snoop_ack  in  2  snooper finished lookup (state updated)
snoop_dirty  in  2  snooper held the line MODIFIED; must flush
snoop_data  in  2xDATA_W  flush data from snooper
mem_ren  out  1  RAM read request
mem_wen  out  1  RAM write request
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_ready  in  1  RAM access complete this cycle
mem_rdata  in  DATA_W  RAM read data, valid with mem_ready

Behaviour:
- Reset (any cycle, including mid-transaction): state IDLE; all outputs 0; last_grant = 1, so cache 0 wins the first tie; latched id/cmd/addr/data cleared. Transactions in flight are abandoned.
- All outputs are Moore, decoded from the state register and latched registers. No combinational path exists from inputs to outputs.
- A request is valid when cache_req[i] = 1 and cache_cmd[i] != IDLE. Requests are sampled only in IDLE.
- States:
  - IDLE: if no valid request, stay. If one is valid, grant it. If both are valid, grant ~last_grant. Latch gid, cmd, addr, wdata. Next state: WB -> MEMWR; BUSRD/BUSRDX/INVALIDATE -> SNOOP. The arbitration cycle is the only cycle spent in IDLE.
  - SNOOP: snoop_valid[~gid] = 1; snoop_cmd/addr = latched values. Hold until snoop_ack[~gid]. On ack:
    - INVALIDATE -> DONE.
    - snoop_dirty[~gid] -> FLUSH; latch snoop_data[~gid].
    - otherwise -> MEMRD.
  - MEMRD: mem_ren = 1, mem_addr = addr. Hold until mem_ready, latch mem_rdata into rdata, then -> DONE.
  - FLUSH: mem_wen = 1, mem_addr = addr, mem_wdata = latched flush data. On mem_ready, rdata = flush data, then -> DONE. This gives the cache-to-cache transfer plus memory update.
  - MEMWR: mem_wen = 1, mem_wdata = wdata. On mem_ready -> DONE.
  - DONE: cache_done[gid] = 1 for exactly one cycle; cache_rdata = rdata (0 for WB/INVALIDATE); last_grant = gid; -> IDLE.
- mem_ren and mem_wen are never both high. mem_ready outside MEMRD/FLUSH/MEMWR is ignored.
- The requester must drop or change its request in the cycle after done. A request still valid in IDLE is a new transaction.
- Minimum latency is counted from the IDLE grant cycle to the done cycle:
  - INVALIDATE: 3 cycles (IDLE, SNOOP with same-cycle ack, DONE).
  - BUSRD with mem_ready in the first cycle: 4 cycles.
  - WB: 3 cycles.
- snoop_ack asserted by the requester itself, or while not in SNOOP, is ignored.
- A cache may request while being snooped. Its request waits until IDLE.
- BUSRDX and BUSRD differ only in snoop_cmd. The snooper invalidates on BUSRDX and downgrades to SHARED on BUSRD.

Decomposition:
- Shared package (cpu_types_pkg / msi header): bus_command and msi_state enums, a bus_state_t enum for {IDLE, SNOOP, MEMRD, FLUSH, MEMWR, DONE}, and cache-count constant NCACHES = 2.
- One sub-module, rr_arbiter2: 2-bit valid vector plus last_grant in, one-hot grant and grant id out, purely combinational.
- The FSM and latches stay in coherence_bus_ctrl.

Test Plan:
- Reset released, cache0 BUSRD addr 0x40, snoop_ack[1] = 1 with dirty = 0, mem_ready after 2 cycles with rdata 0xDEADBEEF -> mem_ren for 2 cycles, cache_done[0] pulse, cache_rdata = 0xDEADBEEF.
- cache1 BUSRDX addr 0x80, snooper 0 acks dirty with data 0x12345678 -> FLUSH: mem_wen, mem_addr 0x80, mem_wdata 0x12345678; cache_done[1] with rdata 0x12345678; mem_ren never asserted.
- Both caches request in the same cycle, back-to-back three times -> grant order 0, 1, 0. Each done is a single-cycle pulse.
- cache0 INVALIDATE addr 0x10 -> snoop_valid[1] with snoop_cmd INVALIDATE; no mem_ren/mem_wen; done 3 cycles after grant with same-cycle ack.
- cache1 WB addr 0x20 data 0xCAFEF00D, mem_ready after 3 cycles -> mem_wen held 3 cycles, no snoop_valid, cache_done[1].
- Assert RST during MEMRD with mem_ren high -> all outputs 0 immediately; after release, a cache1 request wins (last_grant reset to 1 favours cache 0 only on ties).

Source files
------------

// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-core MSI snooping bus:
// bus commands, line states and bus controller states.
package coherence_bus_ctrl_pkg;

  localparam int NCACHES = 2;

  typedef enum logic [2:0] {
    CMD_IDLE       = 3'd0,
    CMD_BUSRD      = 3'd1,
    CMD_BUSRDX     = 3'd2,
    CMD_INVALIDATE = 3'd3,
    CMD_WB         = 3'd4
  } bus_command_t;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_state_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_MEMRD = 3'd2,
    ST_FLUSH = 3'd3,
    ST_MEMWR = 3'd4,
    ST_DONE  = 3'd5
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the cache that
// did not win last time gets the bus.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       gid
);

  always_comb begin
    grant = 2'b00;
    gid   = 1'b0;
    case (valid)
      2'b01: begin
        grant = 2'b01;
        gid   = 1'b0;
      end
      2'b10: begin
        grant = 2'b10;
        gid   = 1'b1;
      end
      2'b11: begin
        gid   = ~last_grant;
        grant = last_grant ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller: arbitrates both L1 dcaches, broadcasts
// snoops and sequences RAM reads, writebacks and dirty flushes.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NCACHES-1:0]              cache_req,
  input  logic [NCACHES-1:0][2:0]         cache_cmd,
  input  logic [NCACHES-1:0][ADDR_W-1:0]  cache_addr,
  input  logic [NCACHES-1:0][DATA_W-1:0]  cache_wdata,
  output logic [NCACHES-1:0]              cache_done,
  output logic [DATA_W-1:0]               cache_rdata,
  output logic [NCACHES-1:0]              snoop_valid,
  output logic [2:0]                      snoop_cmd,
  output logic [ADDR_W-1:0]               snoop_addr,
  input  logic [NCACHES-1:0]              snoop_ack,
  input  logic [NCACHES-1:0]              snoop_dirty,
  input  logic [NCACHES-1:0][DATA_W-1:0]  snoop_data,
  output logic                            mem_ren,
  output logic                            mem_wen,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic                            mem_ready,
  input  logic [DATA_W-1:0]               mem_rdata
);

  bus_state_t   state, state_nxt;
  bus_command_t cmd;
  logic         gid, other, last_grant;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, fdata, rdata;

  logic [1:0] valid, grant;
  logic       arb_gid;

  assign other = ~gid;

  always_comb begin
    for (int i = 0; i < NCACHES; i++)
      valid[i] = cache_req[i] && (cache_cmd[i] != CMD_IDLE);
  end

  rr_arbiter2 u_arb (
    .valid      (valid),
    .last_grant (last_grant),
    .grant      (grant),
    .gid        (arb_gid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      gid        <= 1'b0;
      cmd        <= CMD_IDLE;
      addr       <= '0;
      wdata      <= '0;
      fdata      <= '0;
      rdata      <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: if (grant != 2'b00) begin
          gid   <= arb_gid;
          cmd   <= bus_command_t'(cache_cmd[arb_gid]);
          addr  <= cache_addr[arb_gid];
          wdata <= cache_wdata[arb_gid];
          rdata <= '0;
        end
        ST_SNOOP:
          if (snoop_ack[other] && snoop_dirty[other])
            fdata <= snoop_data[other];
        ST_MEMRD: if (mem_ready) rdata <= mem_rdata;
        ST_FLUSH: if (mem_ready) rdata <= fdata;
        ST_DONE:  last_grant <= gid;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (grant != 2'b00)
          state_nxt = (cache_cmd[arb_gid] == CMD_WB) ? ST_MEMWR : ST_SNOOP;
      ST_SNOOP:
        if (snoop_ack[other]) begin
          if (cmd == CMD_INVALIDATE)   state_nxt = ST_DONE;
          else if (snoop_dirty[other]) state_nxt = ST_FLUSH;
          else                         state_nxt = ST_MEMRD;
        end
      ST_MEMRD, ST_FLUSH, ST_MEMWR:
        if (mem_ready) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs: only state and latched registers feed these.
  always_comb begin
    cache_done  = '0;
    cache_rdata = '0;
    snoop_valid = '0;
    snoop_cmd   = '0;
    snoop_addr  = '0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state)
      ST_SNOOP: begin
        snoop_valid[other] = 1'b1;
        snoop_cmd          = cmd;
        snoop_addr         = addr;
      end
      ST_MEMRD: begin
        mem_ren  = 1'b1;
        mem_addr = addr;
      end
      ST_FLUSH: begin
        mem_wen   = 1'b1;
        mem_addr  = addr;
        mem_wdata = fdata;
      end
      ST_MEMWR: begin
        mem_wen   = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
      end
      ST_DONE: begin
        cache_done[gid] = 1'b1;
        cache_rdata     = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: reads, flushes, writebacks,
// invalidates, round-robin ties and mid-transaction reset.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  logic             CLK, RST;
  logic [1:0]       cache_req;
  logic [1:0][2:0]  cache_cmd;
  logic [1:0][31:0] cache_addr, cache_wdata;
  logic [1:0]       cache_done;
  logic [31:0]      cache_rdata;
  logic [1:0]       snoop_valid;
  logic [2:0]       snoop_cmd;
  logic [31:0]      snoop_addr;
  logic [1:0]       snoop_ack, snoop_dirty;
  logic [1:0][31:0] snoop_data;
  logic             mem_ren, mem_wen;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_ready;
  logic [31:0]      mem_rdata;

  int total = 0;
  int bad   = 0;

  coherence_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cache_req   (cache_req),
    .cache_cmd   (cache_cmd),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_done  (cache_done),
    .cache_rdata (cache_rdata),
    .snoop_valid (snoop_valid),
    .snoop_cmd   (snoop_cmd),
    .snoop_addr  (snoop_addr),
    .snoop_ack   (snoop_ack),
    .snoop_dirty (snoop_dirty),
    .snoop_data  (snoop_data),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    cache_req   = '0;
    cache_cmd   = '0;
    cache_addr  = '0;
    cache_wdata = '0;
    snoop_ack   = '0;
    snoop_dirty = '0;
    snoop_data  = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
  endtask

  int exp_g[3] = '{0, 1, 0};

  initial begin
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_done", cache_done, 2'b00);
    check("rst_snp", snoop_valid, 2'b00);
    check("rst_ren", mem_ren, 1'b0);
    check("rst_wen", mem_wen, 1'b0);
    check("rst_rdata", cache_rdata, 32'h0);
    RST = 1'b0;
    tick();

    // cache0 BUSRD, clean snoop, memory answers on 2nd cycle
    cache_req     = 2'b01;
    cache_cmd[0]  = CMD_BUSRD;
    cache_addr[0] = 32'h40;
    tick();
    cache_req = 2'b00;
    check("t1_snp_valid", snoop_valid, 2'b10);
    check("t1_snp_cmd", snoop_cmd, CMD_BUSRD);
    check("t1_snp_addr", snoop_addr, 32'h40);
    snoop_ack = 2'b01;
    tick();
    check("t1_self_ack", snoop_valid, 2'b10);
    check("t1_no_ren", mem_ren, 1'b0);
    snoop_ack = 2'b10;
    tick();
    snoop_ack = 2'b00;
    check("t1_ren_c1", mem_ren, 1'b1);
    check("t1_maddr", mem_addr, 32'h40);
    tick();
    check("t1_ren_c2", mem_ren, 1'b1);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    check("t1_done", cache_done, 2'b01);
    check("t1_rdata", cache_rdata, 32'hDEADBEEF);
    check("t1_ren_off", mem_ren, 1'b0);
    tick();
    check("t1_pulse", cache_done, 2'b00);

    // cache1 BUSRDX, cache0 holds it modified and flushes
    cache_req     = 2'b10;
    cache_cmd[1]  = CMD_BUSRDX;
    cache_addr[1] = 32'h80;
    tick();
    cache_req = 2'b00;
    check("t2_snp_valid", snoop_valid, 2'b01);
    check("t2_snp_cmd", snoop_cmd, CMD_BUSRDX);
    snoop_ack     = 2'b01;
    snoop_dirty   = 2'b01;
    snoop_data[0] = 32'h12345678;
    tick();
    snoop_ack   = 2'b00;
    snoop_dirty = 2'b00;
    snoop_data  = '0;
    check("t2_wen", mem_wen, 1'b1);
    check("t2_ren", mem_ren, 1'b0);
    check("t2_maddr", mem_addr, 32'h80);
    check("t2_mwdata", mem_wdata, 32'h12345678);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t2_done", cache_done, 2'b10);
    check("t2_rdata", cache_rdata, 32'h12345678);
    check("t2_ren_done", mem_ren, 1'b0);
    tick();

    // cache1 WB, memory ready after 3 cycles
    cache_req      = 2'b10;
    cache_cmd[1]   = CMD_WB;
    cache_addr[1]  = 32'h20;
    cache_wdata[1] = 32'hCAFEF00D;
    tick();
    cache_req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check("t5_wen", mem_wen, 1'b1);
      check("t5_no_snp", snoop_valid, 2'b00);
      if (k == 0) begin
        check("t5_maddr", mem_addr, 32'h20);
        check("t5_mwdata", mem_wdata, 32'hCAFEF00D);
      end
      if (k == 2) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check("t5_done", cache_done, 2'b10);
    check("t5_wen_off", mem_wen, 1'b0);
    check("t5_rdata", cache_rdata, 32'h0);
    tick();

    // both caches keep requesting: grants alternate 0,1,0
    cache_req     = 2'b11;
    cache_cmd[0]  = CMD_INVALIDATE;
    cache_cmd[1]  = CMD_INVALIDATE;
    cache_addr[0] = 32'h100;
    cache_addr[1] = 32'h200;
    snoop_ack     = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_snp", snoop_valid, exp_g[i] == 0 ? 2'b10 : 2'b01);
      check("t3_saddr", snoop_addr, exp_g[i] == 0 ? 32'h100 : 32'h200);
      tick();
      if (i == 2) cache_req = 2'b00;
      check("t3_done", cache_done, exp_g[i] == 0 ? 2'b01 : 2'b10);
      tick();
      check("t3_pulse", cache_done, 2'b00);
    end
    snoop_ack = 2'b00;

    // cache0 INVALIDATE with same-cycle ack: 3 cycles
    cache_req     = 2'b01;
    cache_cmd[0]  = CMD_INVALIDATE;
    cache_addr[0] = 32'h10;
    tick();
    cache_req = 2'b00;
    check("t4_snp", snoop_valid, 2'b10);
    check("t4_scmd", snoop_cmd, CMD_INVALIDATE);
    check("t4_mem", {mem_ren, mem_wen}, 2'b00);
    snoop_ack = 2'b10;
    tick();
    snoop_ack = 2'b00;
    check("t4_done", cache_done, 2'b01);
    check("t4_mem_done", {mem_ren, mem_wen}, 2'b00);
    check("t4_rdata", cache_rdata, 32'h0);
    tick();

    // reset in MEMRD, then tie goes to cache0, then cache1 alone
    cache_req     = 2'b01;
    cache_cmd[0]  = CMD_BUSRD;
    cache_addr[0] = 32'h40;
    tick();
    cache_req = 2'b00;
    snoop_ack = 2'b10;
    tick();
    snoop_ack = 2'b00;
    check("t6_ren", mem_ren, 1'b1);
    RST = 1'b1;
    #1;
    check("t6_rst_ren", mem_ren, 1'b0);
    check("t6_rst_addr", mem_addr, 32'h0);
    check("t6_rst_out", {cache_done, snoop_valid, mem_wen}, 5'b0);
    tick();
    RST = 1'b0;
    cache_req     = 2'b11;
    cache_cmd[0]  = CMD_INVALIDATE;
    cache_cmd[1]  = CMD_INVALIDATE;
    snoop_ack     = 2'b11;
    tick();
    check("t6_tie", snoop_valid, 2'b10);
    cache_req = 2'b10;
    tick();
    check("t6_done0", cache_done, 2'b01);
    tick();
    tick();
    check("t6_grant1", snoop_valid, 2'b01);
    tick();
    cache_req = 2'b00;
    check("t6_done1", cache_done, 2'b10);
    tick();
    check("t6_idle", cache_done, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
